// File: rtl/stack_word_ctrl_pkg.sv
// Shared types for the word-wide stack controller: request opcodes, FSM states and widths.
package stack_word_ctrl_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_HI,
        S_PUSH_LO,
        S_POP_LO,
        S_POP_HI,
        S_POP_CAP,
        S_DONE
    } state_e;

    // POP and RET both read a word back from the stack.
    function automatic logic isPopOp(input op_e op);
        return (op == OP_POP) || (op == OP_RET);
    endfunction

endpackage

// File: rtl/stack_word_ctrl_if.sv
// Request/response, IP-load and byte-stack signals of the word stack controller.
// master = execute unit plus stack side, slave = the controller itself.
interface stack_word_ctrl_if #(parameter int DEPTH = 256);
    import stack_word_ctrl_pkg::*;

    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [WORD_W-1:0] req_data;
    logic [WORD_W-1:0] cur_ip;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_data;
    logic              rsp_err;
    logic              ip_load;
    logic [WORD_W-1:0] ip_out;
    logic              stk_push;
    logic              stk_pop;
    logic [BYTE_W-1:0] stk_in;
    logic [BYTE_W-1:0] stk_out;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output req_valid, req_op, req_data, cur_ip, stk_out,
        input  req_ready, rsp_valid, rsp_data, rsp_err, ip_load, ip_out,
               stk_push, stk_pop, stk_in, occupancy
    );

    modport slave (
        input  req_valid, req_op, req_data, cur_ip, stk_out,
        output req_ready, rsp_valid, rsp_data, rsp_err, ip_load, ip_out,
               stk_push, stk_pop, stk_in, occupancy
    );

endinterface

// File: rtl/stack_word_ctrl.sv
// Splits 16-bit PUSH/POP/CALL/RET requests into ordered byte strobes for the byte stack.
// Define STACK_WORD_CTRL_BOUNDS_CHECK_EN to reject overflowing pushes and underflowing pops.
module stack_word_ctrl
    import stack_word_ctrl_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input logic             clk,
    input logic             rst,
    stack_word_ctrl_if.slave bus
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    state_e            r_state;
    state_e            w_next;
    op_e               r_op;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] r_target;
    logic [OCC_W-1:0]  r_occ;

    logic              w_accept;
    logic              w_reject;
    logic              w_err;
    logic              w_push;
    logic              w_pop;
    logic [BYTE_W-1:0] w_stkIn;
    logic              w_rspValid;
    logic [WORD_W-1:0] w_rspData;
    logic              w_ipLoad;
    logic [WORD_W-1:0] w_ipOut;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

`ifdef STACK_WORD_CTRL_BOUNDS_CHECK_EN
    localparam logic [OCC_W-1:0] OCC_HI  = OCC_W'(DEPTH - 2);
    localparam logic [OCC_W-1:0] OCC_MIN = OCC_W'(2);

    logic r_err;

    assign w_reject = isPopOp(op_e'(bus.req_op)) ? (r_occ < OCC_MIN) : (r_occ > OCC_HI);
    assign w_err    = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_reject;
        end
    end
`else
    assign w_reject = 1'b0;
    assign w_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A rejected request skips the stack states entirely, so no strobe can fire for it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_reject)
                        w_next = S_DONE;
                    else if (isPopOp(op_e'(bus.req_op)))
                        w_next = S_POP_LO;
                    else
                        w_next = S_PUSH_HI;
                end
            end
            S_PUSH_HI: w_next = S_PUSH_LO;
            S_PUSH_LO: w_next = S_DONE;
            S_POP_LO:  w_next = S_POP_HI;
            S_POP_HI:  w_next = S_POP_CAP;
            S_POP_CAP: w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_stkIn    = '0;
        w_rspValid = 1'b0;
        w_rspData  = '0;
        w_ipLoad   = 1'b0;
        w_ipOut    = '0;
        case (r_state)
            S_PUSH_HI: begin
                w_push  = 1'b1;
                w_stkIn = r_word[15:8];
            end
            S_PUSH_LO: begin
                w_push  = 1'b1;
                w_stkIn = r_word[7:0];
            end
            S_POP_LO, S_POP_HI: w_pop = 1'b1;
            S_DONE: begin
                w_rspValid = 1'b1;
                if (!w_err) begin
                    case (r_op)
                        OP_POP: w_rspData = r_word;
                        OP_RET: begin
                            w_rspData = r_word;
                            w_ipLoad  = 1'b1;
                            w_ipOut   = r_word;
                        end
                        OP_CALL: begin
                            w_ipLoad = 1'b1;
                            w_ipOut  = r_target;
                        end
                        default: w_rspData = '0;
                    endcase
                end
            end
            default: w_push = 1'b0;
        endcase
    end

    // CALL pushes the return address, so the holding register takes cur_ip instead of req_data.
    // Popped bytes arrive low byte first, one cycle after each pop strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_PUSH;
            r_word   <= '0;
            r_target <= '0;
            r_occ    <= '0;
        end else begin
            if (w_accept) begin
                r_op     <= op_e'(bus.req_op);
                r_target <= bus.req_data;
                r_word   <= (op_e'(bus.req_op) == OP_CALL) ? bus.cur_ip : bus.req_data;
            end else if (r_state == S_POP_HI) begin
                r_word[7:0] <= bus.stk_out;
            end else if (r_state == S_POP_CAP) begin
                r_word[15:8] <= bus.stk_out;
            end
            if (w_push)
                r_occ <= r_occ + 1'b1;
            else if (w_pop)
                r_occ <= r_occ - 1'b1;
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = w_rspValid;
    assign bus.rsp_data  = w_rspData;
    assign bus.rsp_err   = w_rspValid && w_err;
    assign bus.ip_load   = w_ipLoad;
    assign bus.ip_out    = w_ipOut;
    assign bus.stk_push  = w_push;
    assign bus.stk_pop   = w_pop;
    assign bus.stk_in    = w_stkIn;
    assign bus.occupancy = r_occ;

endmodule

// File: tb/tb_stack_word_ctrl.sv
// Directed bench for stack_word_ctrl with a byte-stack model on the stack port.
// Bounds-check scenarios run only when STACK_WORD_CTRL_BOUNDS_CHECK_EN is defined.
module tb_stack_word_ctrl;
    import stack_word_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    stack_word_ctrl_if #(.DEPTH(256)) bus ();

    stack_word_ctrl #(.DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte stack model: registered output valid the cycle after a pop strobe, shares rst.
    logic [7:0] stackMem [0:255];
    logic [8:0] stackSp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stackSp     <= '0;
            bus.stk_out <= '0;
        end else if (bus.stk_push) begin
            stackMem[stackSp[7:0]] <= bus.stk_in;
            stackSp                <= stackSp + 9'd1;
        end else if (bus.stk_pop) begin
            bus.stk_out <= stackMem[stackSp[7:0] - 8'd1];
            stackSp     <= stackSp - 9'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one request for a single cycle; returns at c1 (1 ns after the accept edge).
    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] data, input logic [15:0] ip);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = data;
        bus.cur_ip    = ip;
        testsRun++;
        if (bus.req_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL req_ready_idle: got %b expected 1", bus.req_ready);
        end
        step();
        bus.req_valid = 1'b0;
        bus.req_data  = 16'h0000;
        bus.cur_ip    = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        testsRun++;
        if ({bus.rsp_valid, bus.rsp_err, bus.ip_load, bus.stk_push, bus.stk_pop} !== 5'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobes: got %b expected 00000",
                     {bus.rsp_valid, bus.rsp_err, bus.ip_load, bus.stk_push, bus.stk_pop});
        end
        testsRun++;
        if ({bus.rsp_data, bus.ip_out, bus.stk_in} !== 40'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: got %h expected 0", {bus.rsp_data, bus.ip_out, bus.stk_in});
        end
        testsRun++;
        if (bus.occupancy !== 9'd0 || bus.req_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_occ_ready: got occ=%0d ready=%b expected occ=0 ready=1",
                     bus.occupancy, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // PUSH/CALL: hi byte at c1, lo byte at c2, DONE at c3.
    task automatic test_push_seq(input string name, input logic [1:0] op, input logic [15:0] data,
                                 input logic [15:0] ip, input logic [8:0] occAfter);
        logic [15:0] word;
        word = (op == OP_CALL) ? ip : data;
        applyStimulus(op, data, ip);
        testsRun++;
        if (bus.stk_push !== 1'b1 || bus.stk_pop !== 1'b0 || bus.stk_in !== word[15:8]) begin
            testsFailed++;
            $display("[TB] FAIL %s_c1: got push=%b pop=%b in=%h expected push=1 pop=0 in=%h",
                     name, bus.stk_push, bus.stk_pop, bus.stk_in, word[15:8]);
        end
        step();
        testsRun++;
        if (bus.stk_push !== 1'b1 || bus.stk_in !== word[7:0] || bus.rsp_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s_c2: got push=%b in=%h vld=%b expected push=1 in=%h vld=0",
                     name, bus.stk_push, bus.stk_in, bus.rsp_valid, word[7:0]);
        end
        step();
        testsRun++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.stk_push !== 1'b0 ||
            bus.rsp_data !== 16'h0 || bus.req_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s_done: got vld=%b err=%b push=%b data=%h rdy=%b expected 1 0 0 0000 0",
                     name, bus.rsp_valid, bus.rsp_err, bus.stk_push, bus.rsp_data, bus.req_ready);
        end
        testsRun++;
        if (bus.ip_load !== (op == OP_CALL) || bus.ip_out !== ((op == OP_CALL) ? data : 16'h0)) begin
            testsFailed++;
            $display("[TB] FAIL %s_ip: got load=%b ip=%h expected load=%b ip=%h", name, bus.ip_load,
                     bus.ip_out, (op == OP_CALL), ((op == OP_CALL) ? data : 16'h0));
        end
        testsRun++;
        if (bus.occupancy !== occAfter) begin
            testsFailed++;
            $display("[TB] FAIL %s_occ: got %0d expected %0d", name, bus.occupancy, occAfter);
        end
        step();
    endtask

    // POP/RET: pop strobes at c1 and c2 only, DONE with the word at c4.
    task automatic test_pop_seq(input string name, input logic [1:0] op, input logic [15:0] expWord,
                                input logic [8:0] occAfter);
        logic [3:0] popTrace;
        popTrace = '0;
        applyStimulus(op, 16'h0, 16'h0);
        for (int c = 0; c < 3; c++) begin
            popTrace[c] = bus.stk_pop | bus.stk_push;
            if (c < 2) step();
        end
        testsRun++;
        if (popTrace[2:0] !== 3'b011) begin
            testsFailed++;
            $display("[TB] FAIL %s_strobes: got c3..c1=%b expected 011", name, popTrace[2:0]);
        end
        step();
        testsRun++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== expWord || bus.rsp_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s_done: got vld=%b data=%h err=%b expected vld=1 data=%h err=0",
                     name, bus.rsp_valid, bus.rsp_data, bus.rsp_err, expWord);
        end
        testsRun++;
        if (bus.ip_load !== (op == OP_RET) || bus.ip_out !== ((op == OP_RET) ? expWord : 16'h0)) begin
            testsFailed++;
            $display("[TB] FAIL %s_ip: got load=%b ip=%h expected load=%b ip=%h", name, bus.ip_load,
                     bus.ip_out, (op == OP_RET), ((op == OP_RET) ? expWord : 16'h0));
        end
        testsRun++;
        if (bus.occupancy !== occAfter) begin
            testsFailed++;
            $display("[TB] FAIL %s_occ: got %0d expected %0d", name, bus.occupancy, occAfter);
        end
        step();
        testsRun++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s_idle: got rdy=%b vld=%b expected rdy=1 vld=0",
                     name, bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_push_pop();
        test_push_seq("push_a55a", OP_PUSH, 16'hA55A, 16'h0, 9'd2);
        test_pop_seq("pop_a55a", OP_POP, 16'hA55A, 9'd0);
    endtask

    task automatic test_call_ret();
        test_push_seq("call", OP_CALL, 16'h0200, 16'h0103, 9'd2);
        test_pop_seq("ret", OP_RET, 16'h0103, 9'd0);
    endtask

    task automatic test_back_to_back();
        test_push_seq("push_1234", OP_PUSH, 16'h1234, 16'h0, 9'd2);
        test_push_seq("push_beef", OP_PUSH, 16'hBEEF, 16'h0, 9'd4);
        test_pop_seq("pop_beef", OP_POP, 16'hBEEF, 9'd2);
        test_pop_seq("pop_1234", OP_POP, 16'h1234, 9'd0);
    endtask

`ifdef STACK_WORD_CTRL_BOUNDS_CHECK_EN
    task automatic test_bounds();
        applyStimulus(OP_POP, 16'h0, 16'h0);
        testsRun++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.stk_pop !== 1'b0 ||
            bus.stk_push !== 1'b0 || bus.rsp_data !== 16'h0 || bus.occupancy !== 9'd0) begin
            testsFailed++;
            $display("[TB] FAIL underflow: got vld=%b err=%b pop=%b push=%b data=%h occ=%0d expected 1 1 0 0 0000 0",
                     bus.rsp_valid, bus.rsp_err, bus.stk_pop, bus.stk_push, bus.rsp_data, bus.occupancy);
        end
        step();
        for (int n = 0; n < 128; n++) begin
            applyStimulus(OP_PUSH, 16'(n), 16'h0);
            step();
            step();
            testsRun++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL fill_%0d: got vld=%b err=%b expected vld=1 err=0",
                         n, bus.rsp_valid, bus.rsp_err);
            end
            step();
        end
        testsRun++;
        if (bus.occupancy !== 9'd256) begin
            testsFailed++;
            $display("[TB] FAIL full_occ: got %0d expected 256", bus.occupancy);
        end
        applyStimulus(OP_CALL, 16'h0300, 16'h0104);
        testsRun++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.stk_push !== 1'b0 ||
            bus.ip_load !== 1'b0 || bus.occupancy !== 9'd256) begin
            testsFailed++;
            $display("[TB] FAIL overflow: got vld=%b err=%b push=%b load=%b occ=%0d expected 1 1 0 0 256",
                     bus.rsp_valid, bus.rsp_err, bus.stk_push, bus.ip_load, bus.occupancy);
        end
        step();
    endtask
`endif

    task automatic test_reset_mid_pop();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        test_push_seq("push_7788", OP_PUSH, 16'h7788, 16'h0, 9'd2);
        applyStimulus(OP_POP, 16'h0, 16'h0);
        step();
        rst = 1'b1;
        #1;
        testsRun++;
        if ({bus.rsp_valid, bus.rsp_err, bus.ip_load, bus.stk_push, bus.stk_pop} !== 5'b0 ||
            bus.rsp_data !== 16'h0 || bus.ip_out !== 16'h0 || bus.occupancy !== 9'd0 ||
            bus.req_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset: got flags=%b data=%h ip=%h occ=%0d rdy=%b expected 00000 0000 0000 0 1",
                     {bus.rsp_valid, bus.rsp_err, bus.ip_load, bus.stk_push, bus.stk_pop},
                     bus.rsp_data, bus.ip_out, bus.occupancy, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            testsRun++;
            if (bus.rsp_valid !== 1'b0 || bus.stk_pop !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL mid_reset_quiet_%0d: got vld=%b pop=%b expected 0 0",
                         c, bus.rsp_valid, bus.stk_pop);
            end
        end
        test_push_seq("push_after_rst", OP_PUSH, 16'h0F1E, 16'h0, 9'd2);
        test_pop_seq("pop_after_rst", OP_POP, 16'h0F1E, 9'd0);
    endtask

    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_data  = 16'h0;
        bus.cur_ip    = 16'h0;
        test_reset();
        test_push_pop();
        test_call_ret();
        test_back_to_back();
`ifdef STACK_WORD_CTRL_BOUNDS_CHECK_EN
        test_bounds();
`endif
        test_reset_mid_pop();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/stack_word_ctrl.md
Name: stack_word_ctrl

Overview:
- Initiator-side controller for the byte-wide stack: turns 16-bit PUSH/POP/CALL/RET requests from the execution unit into ordered byte push/pop strobes to the stack.
- Collects popped bytes back into 16-bit words and drives IP loads for CALL/RET.
- Sits between the execute FSM and the stack. Tracks stack occupancy and, optionally, rejects overflow and underflow.

Parameters:
- DEPTH, 256: stack capacity in bytes. The occupancy counter is clog2(DEPTH)+1 bits wide.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  controller can accept (high only in IDLE)
- req_op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET
- req_data  in  16  PUSH: word to push; CALL: branch target
- cur_ip  in  16  IP of the next instruction; sampled on CALL accept
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  16  popped word (POP/RET); 0 otherwise
- rsp_err  out  1  request rejected, with rsp_valid
- ip_load  out  1  load IP this cycle (CALL/RET success, with rsp_valid)
- ip_out  out  16  new IP value
- stk_push  out  1  stack push strobe
- stk_pop  out  1  stack pop strobe
- stk_in  out  8  byte to push
- stk_out  in  8  stack registered output; valid the cycle after a pop strobe
- occupancy  out  clog2(DEPTH)+1  bytes currently on the stack

Behaviour:
- Reset, asynchronous:
  - state=IDLE, occupancy=0.
  - All strobes and rsp/ip outputs 0; rsp_data=0, ip_out=0.
  - The stack shares rst, so its SP re-initialises in the same event.
- Reset mid-operation aborts the request. No response is issued.
- Handshake: a request is accepted when req_valid && req_ready. req_op, req_data and cur_ip are latched at accept.
- States:
  - IDLE
  - PUSH_HI, PUSH_LO
  - POP_LO, POP_HI, POP_CAP
  - DONE
- PUSH (cycle 0 = accept):
  - c1 PUSH_HI: stk_push=1, stk_in=data[15:8].
  - c2 PUSH_LO: stk_push=1, stk_in=data[7:0].
  - c3 DONE.
- CALL: same sequence as PUSH, but the pushed word is the latched cur_ip. In DONE: ip_load=1, ip_out=target.
- POP/RET:
  - c1 POP_LO: stk_pop=1.
  - c2 POP_HI: stk_pop=1; capture stk_out into the low byte.
  - c3 POP_CAP: capture stk_out into the high byte.
  - c4 DONE: rsp_data=word.
  - RET additionally drives ip_load=1, ip_out=word in DONE.
- DONE lasts one cycle: rsp_valid=1, then return to IDLE. req_ready=0 in DONE, so there is no back-to-back accept in the same cycle.
- stk_push and stk_pop are never high together. At most one strobe per cycle.
- Occupancy:
  - +1 on each stk_push, -1 on each stk_pop.
  - Saturating arithmetic is not required; the checks below prevent wrap.
- Byte order is high byte first on push, low byte first on pop. This keeps LIFO order word-consistent.
- Outputs are registered. Strobes are decoded from the state register.

Optional Feature:
- Macro: STACK_WORD_CTRL_BOUNDS_CHECK_EN.
- Defined:
  - A PUSH/CALL with occupancy > DEPTH-2, or a POP/RET with occupancy < 2, skips the stack states and goes straight to DONE.
  - In DONE: rsp_valid=1, rsp_err=1, ip_load=0, rsp_data=0.
  - No strobes are issued and occupancy is unchanged.
- Undefined: no checks; rsp_err is tied 0 and occupancy is reported unchanged.

Decomposition:
- Package stack_word_ctrl_pkg holds:
  - op encodings OP_PUSH/OP_POP/OP_CALL/OP_RET
  - the state enum
  - WORD_W=16, BYTE_W=8
- A single FSM module. No sub-module is natural: the datapath is a 16-bit holding register plus the counter.

Test Plan:
- Reset, then PUSH 0xA55A:
  - stk_in=0xA5 at c1 and 0x5A at c2.
  - rsp_valid at c3, occupancy=2.
- After that push, POP, with the stack model attached:
  - rsp_data=0xA55A at c4, occupancy=0.
  - stk_pop high exactly at c1 and c2.
- CALL with req_data=0x0200, cur_ip=0x0103: bytes 0x01, 0x03 pushed; DONE has ip_load=1, ip_out=0x0200.
- Then RET: ip_load=1, ip_out=0x0103.
- With BOUNDS_CHECK_EN:
  - POP at occupancy 0 gives rsp_err=1 at c1 with no strobes.
  - 128 PUSHes with DEPTH=256 all succeed; the 129th errors.
- Assert rst during POP_HI: all outputs 0 immediately, occupancy=0, and the next PUSH starts cleanly.
